lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Multi-cycle load/store controller between the RV32I core's execute stage and a data memory with a request/acknowledge handshake. It accepts one access at a time and generates the word-aligned address, byte enables and lane-replicated store data. Load data is realigned from the addressed byte lane and sign- or zero-extended per funct3. It stalls the core until the access completes or times out.

## Interface
- TIMEOUT, 255: max cycles in ACCESS without mem_ack before a bus error; 0 disables the timeout.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core issues a load/store.
- req_ready  out  1  controller idle, can accept.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3 or timeout; qualified by rsp_valid.
- stall  out  1  core must hold; high whenever state != IDLE.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted write / returned read data.
- mem_rdata  in  32  read word, valid with mem_ack.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch we/func3/addr/wdata and classify:
  - illegal funct3 (load 011/110/111; store other than 000/001/010) -> RESP, rsp_err=1, no memory access, under every configuration;
  - misaligned access -> see Configuration;
  - otherwise -> ACCESS.
- ACCESS: mem_req=1, mem_* stable.
  - mem_ack: capture mem_rdata, go to RESP with err=0.
  - Timeout counter reaches TIMEOUT with no ack: drop mem_req, go to RESP with err=1.
  - Ack and timeout in the same cycle: ack wins.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- mem_ack outside ACCESS is ignored.
- Loads:
  - mem_be=4'b1111, mem_we=0.
  - Shift the word right by 8*addr[1:0].
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.
- Stores:
  - sb: mem_be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: mem_be = 4'b0011 << {addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - sw: mem_be = 4'b1111, wdata passes through.
- Misaligned means: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0] != 0.

## Timing
- Reset:
  - state = IDLE; timeout counter = 0.
  - rsp_valid, rsp_err, mem_req, mem_we = 0; rsp_rdata, mem_addr, mem_be, mem_wdata = 0.
  - req_ready = 0 while rst is high, 1 in the first cycle after.
- Latency: request accepted at edge N; mem_req is high in cycle N+1; ack at cycle N+k gives rsp_valid at N+k+1.
  - Minimum load-to-response is 2 cycles.
  - Error without access: rsp_valid at N+1.
- Back-to-back: a new request may be accepted in the cycle after rsp_valid.
- Timeout: counter clears on entry to ACCESS and increments each ACCESS cycle without ack. Expiry at count == TIMEOUT gives rsp_valid TIMEOUT+1 cycles after entry.
- rst mid-access: mem_req drops the next cycle and no rsp_valid is produced.
- rsp_rdata and rsp_err hold their values until the next rsp_valid.

## Configuration
- MISALIGN_TRAP_EN defined: a misaligned access goes IDLE -> RESP with rsp_err=1, rsp_rdata=0 and no mem_req.
- MISALIGN_TRAP_EN undefined: the address is force-aligned (lh/lhu/sh clear addr[0]; lw/sw clear addr[1:0]) and the access proceeds normally with rsp_err=0.

## Structure
- Package lsu_pkg holds:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW);
  - the state enum.
- Sub-module ld_align: combinational lane shift plus sign/zero extension, taking func3, addr[1:0] and the word, and returning the extended result.

## Test plan
- lb at addr 0x103, mem_rdata 0x80FF_1234, ack in the first ACCESS cycle -> rsp_rdata 0xFFFF_FF80 at accept+2, mem_addr 0x100, mem_be 4'b1111.
- sh at addr 0x22, wdata 0x0000_ABCD -> mem_be 4'b1100, mem_wdata 0xABCD_ABCD, mem_we=1, rsp_rdata 0.
- lhu at addr 0x41, macro defined -> rsp_err=1 at accept+1, mem_req never asserted. Macro undefined -> mem_addr 0x40, result taken from lane 0.
- lw with mem_ack never asserted, TIMEOUT=4 -> mem_req high for 5 cycles, then rsp_valid with rsp_err=1.
- Load with funct3 3'b110 -> rsp_err=1, rsp_rdata 0, no memory access.
- rst asserted during ACCESS -> mem_req=0 the next cycle, no rsp_valid, req_ready=1 after rst deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 encodings, FSM states
// and small request-classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // f3[1:0] encodes access size: 0 byte, 1 half, 2 word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and data-memory handshake bundle for lsu_ctrl.
// slave is the controller's view; master is the core + memory side.
interface lsu_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/ld_align.sv
// Load data realignment: shifts the addressed lane down to bit 0 and
// sign- or zero-extends according to funct3.
module ld_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {addr_lo_i, 3'b000};
    case (func3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data_o = {24'h0, shifted[7:0]};
      F3_LHU:  data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: one access at a time over a req/ack memory port.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  lsu_ctrl_if.slave  bus
);

`ifdef MISALIGN_TRAP_EN
  localparam bit MisalignTrap = 1'b1;
`else
  localparam bit MisalignTrap = 1'b0;
`endif

  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept;

  logic        req_legal, req_mis;
  logic [31:0] eff_addr;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_data;

  ld_align u_ld_align (
    .func3_i   (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .word_i    (bus.mem_rdata),
    .data_o    (ld_data)
  );

  // Request classification and lane steering, evaluated on the incoming request.
  always_comb begin
    req_legal = f3_legal(bus.req_we, bus.req_func3);
    req_mis   = f3_misaligned(bus.req_func3, bus.req_addr[1:0]);
    eff_addr  = bus.req_addr;
    if (req_mis && !MisalignTrap) begin
      eff_addr[0] = 1'b0;
      if (bus.req_func3[1]) eff_addr[1] = 1'b0;
    end
    be_new    = 4'b1111;
    wdata_new = bus.req_wdata;
    if (bus.req_we) begin
      case (bus.req_func3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << eff_addr[1:0];
          wdata_new = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << {eff_addr[1], 1'b0};
          wdata_new = {2{bus.req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (!req_legal || (req_mis && MisalignTrap)) begin
            state_d = StResp;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else begin
            state_d = StAccess;
            cnt_d   = 32'h0;
          end
        end
      end
      StAccess: begin
        if (bus.mem_ack) begin
          state_d = StResp;
          rdata_d = we_q ? 32'h0 : ld_data;
          err_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT)) begin
          state_d = StResp;
          rdata_d = 32'h0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 32'h0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_func3;
        addr_q  <= eff_addr;
        be_q    <= be_new;
        wdata_q <= wdata_new;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign bus.stall     = state_q != StIdle;
  assign bus.rsp_valid = state_q == StResp;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_req   = state_q == StAccess;
  assign bus.mem_we    = we_q && (state_q == StAccess);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized loads/stores
// compared against an arithmetic reference model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int unsigned TO = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  lsu_ctrl_if bus ();

  lsu_ctrl #(
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic bit m_legal(input bit we, input int unsigned f3);
    if (we) return f3 <= 2;
    return (f3 <= 2) || (f3 == 4) || (f3 == 5);
  endfunction

  // Reference model of one transaction, straight from the access rules.
  task automatic do_txn(input bit we, input int unsigned f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int unsigned dly);
    int unsigned sz, off, n_acc;
    bit          mis, pre_err, timeout;
    logic [31:0] ea, exp_be, exp_wd, exp_rd, v;
    sz      = 1 << (f3 % 4);
    mis     = m_legal(we, f3) && ((addr % sz) != 0);
    pre_err = !m_legal(we, f3) || (mis && Trap);
    ea      = mis ? addr - (addr % sz) : addr;
    off     = ea % 4;
    exp_be  = we ? (((1 << sz) - 1) << off) : 15;
    if (sz == 1)      exp_wd = (wd % 256) * 32'h0101_0101;
    else if (sz == 2) exp_wd = (wd % 65536) * 32'h0001_0001;
    else              exp_wd = wd;
    v = rd >> (8 * off);
    if (sz < 4) begin
      v = v % (1 << (8 * sz));
      if (f3 < 4 && v >= (1 << (8 * sz - 1))) v = v - (1 << (8 * sz));
    end
    timeout = dly > TO;
    exp_rd  = (we || timeout) ? 32'h0 : v;

    @(negedge clk);
    check_eq("ready_before", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func3 = f3[2:0];
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    if (pre_err) begin
      @(negedge clk);
      check_eq("err_vld", bus.rsp_valid, 1);
      check_eq("err_noreq", bus.mem_req, 0);
      check_eq("err_flag", bus.rsp_err, 1);
      check_eq("err_rdata", bus.rsp_rdata, 0);
    end else begin
      n_acc = timeout ? TO + 1 : dly + 1;
      for (int i = 0; i < n_acc; i++) begin
        @(negedge clk);
        check_eq("acc_req", bus.mem_req, 1);
        check_eq("acc_novld", bus.rsp_valid, 0);
        check_eq("acc_stall", bus.stall, 1);
        if (i == 0) begin
          check_eq("mem_addr", bus.mem_addr, {ea[31:2], 2'b00});
          check_eq("mem_be", {28'h0, bus.mem_be}, exp_be);
          check_eq("mem_we", bus.mem_we, we);
          if (we) check_eq("mem_wdata", bus.mem_wdata, exp_wd);
        end
        if (!timeout && i == dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd;
        end
      end
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      @(negedge clk);
      check_eq("rsp_vld", bus.rsp_valid, 1);
      check_eq("rsp_noreq", bus.mem_req, 0);
      check_eq("rsp_err", bus.rsp_err, timeout);
      check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
    end
    @(negedge clk);
    check_eq("post_novld", bus.rsp_valid, 0);
    check_eq("post_ready", bus.req_ready, 1);
    check_eq("hold_rdata", bus.rsp_rdata, pre_err ? 32'h0 : exp_rd);
  endtask

  task automatic idle_ack();
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_eq("idle_ack_novld", bus.rsp_valid, 0);
    check_eq("idle_ack_ready", bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", bus.req_ready, 0);
    check_eq("rst_vld", bus.rsp_valid, 0);
    check_eq("rst_err", bus.rsp_err, 0);
    check_eq("rst_req", bus.mem_req, 0);
    check_eq("rst_we", bus.mem_we, 0);
    check_eq("rst_addr", bus.mem_addr, 0);
    check_eq("rst_be", {28'h0, bus.mem_be}, 0);
    check_eq("rst_wdata", bus.mem_wdata, 0);
    check_eq("rst_rdata", bus.rsp_rdata, 0);
    check_eq("rst_stall", bus.stall, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_after", bus.req_ready, 1);

    do_txn(1'b0, 0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);   // lb
    do_txn(1'b1, 1, 32'h0000_0022, 32'h0000_ABCD, 32'h0, 1);   // sh
    do_txn(1'b0, 5, 32'h0000_0041, 32'h0, 32'h1234_8678, 2);   // lhu misaligned
    do_txn(1'b0, 2, 32'h0000_0200, 32'h0, 32'h0, TO + 1);      // lw timeout
    do_txn(1'b0, 6, 32'h0000_0300, 32'h0, 32'h0, 0);           // illegal load
    do_txn(1'b0, 2, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, TO);  // ack at expiry
    idle_ack();

    // Reset in the middle of an access.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'b010;
    bus.req_addr  = 32'h0000_0400;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_req", bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_req", bus.mem_req, 0);
    check_eq("mid_rst_vld", bus.rsp_valid, 0);
    check_eq("mid_rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_after_ready", bus.req_ready, 1);
    check_eq("mid_after_vld", bus.rsp_valid, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) idle_ack();
      do_txn(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom, $urandom, $urandom,
             $urandom_range(0, TO + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
